// File: rtl/rotary_pkg.sv
// Shared register map, bit positions, FSM states and control-register layout
// for the rotary value register block.
package rotary_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_EVENTS = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_WRAP    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_STEP_LO = 4;

  localparam int ST_CW    = 0;
  localparam int ST_CCW   = 1;
  localparam int ST_LIMIT = 2;

  localparam logic signed [15:0] EVENTS_MAX = 16'sh7FFF;
  localparam logic signed [15:0] EVENTS_MIN = -16'sh7FFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] step;
    logic       irq_en;
    logic       wrap;
    logic       enable;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_ENABLE] = c.enable;
    w[CTRL_WRAP] = c.wrap;
    w[CTRL_IRQ_EN] = c.irq_en;
    w[CTRL_STEP_LO +: 4] = c.step;
    return w;
  endfunction

endpackage

// File: rtl/rotary_step_calc.sv
// Combinational step: value +/- step in 9 bits, then wrap modulo 256 or clamp
// to 0/255 (flagging limit when a clamp happens). dir = 1 means counter-clockwise.
module rotary_step_calc
  import rotary_pkg::*;
(
  input  logic [7:0] value,
  input  logic [3:0] step,
  input  logic       dir,
  input  logic       wrap,
  output logic [7:0] next_value,
  output logic       limit
);

  logic [8:0] sum;

  always_comb begin
    sum = dir ? ({1'b0, value} - {5'd0, step}) : ({1'b0, value} + {5'd0, step});
    next_value = sum[7:0];
    limit = 1'b0;
    // Bit 8 is the carry on increment and the borrow on decrement.
    if (!wrap && sum[8]) begin
      limit = 1'b1;
      next_value = dir ? 8'h00 : 8'hFF;
    end
  end

endmodule

// File: rtl/rotary_value_reg.sv
// Rotary value register: steps an 8-bit value on cw/ccw pulses and exposes it
// over Avalon-MM. Optional acceleration is built when ROTARY_ACCEL_EN is defined.
module rotary_value_reg
  import rotary_pkg::*;
#(
  parameter logic [7:0]  RESET_VALUE  = 8'd0,
  parameter logic [3:0]  DEFAULT_STEP = 4'd1,
  parameter logic [19:0] ACCEL_WINDOW = 20'd500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rotary_cw,
  input  logic        rotary_ccw,
  output logic [7:0]  value,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  // Handshake: no back-pressure; avs_read/avs_write are single-cycle strobes,
  // avs_readdata is valid the cycle after avs_read and holds until the next read.
  state_t             state;
  ctrl_t              ctrl;
  logic [2:0]         status;
  logic signed [15:0] events;
  logic               pend_dir;
  logic [3:0]         pend_step;

  logic       value_wr, accepted, calc_limit;
  logic [3:0] base_step, eff_step;
  logic [7:0] calc_next;
  logic [2:0] status_set, status_clr;
  logic       unused_wdata;

  assign value_wr  = avs_write && (avs_address == ADDR_VALUE);
  assign accepted  = ctrl.enable && (rotary_cw ^ rotary_ccw) && !value_wr;
  assign base_step = (ctrl.step == 4'd0) ? 4'd1 : ctrl.step;
  assign unused_wdata = ^avs_writedata[31:8];

`ifdef ROTARY_ACCEL_EN
  logic [19:0] interval;
  logic        last_dir;
  logic [5:0]  step_x4;
  logic        fast;

  assign step_x4 = {base_step, 2'b00};
  assign fast = (interval < ACCEL_WINDOW) && (rotary_ccw == last_dir);
  assign eff_step = !fast ? base_step : ((step_x4 > 6'd15) ? 4'd15 : step_x4[3:0]);

  // Starts saturated so the first event after reset is never "fast".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval <= ACCEL_WINDOW;
      last_dir <= 1'b0;
    end else if (accepted) begin
      interval <= 20'd0;
      last_dir <= rotary_ccw;
    end else if (interval < ACCEL_WINDOW) begin
      interval <= interval + 20'd1;
    end
  end
`else
  logic unused_accel;
  assign unused_accel = ^ACCEL_WINDOW;
  assign eff_step = base_step;
`endif

  rotary_step_calc u_step_calc (
    .value      (value),
    .step       (pend_step),
    .dir        (pend_dir),
    .wrap       (ctrl.wrap),
    .next_value (calc_next),
    .limit      (calc_limit)
  );

  always_comb begin
    status_set = '0;
    status_set[ST_CW] = ctrl.enable && rotary_cw;
    status_set[ST_CCW] = ctrl.enable && rotary_ccw;
    status_set[ST_LIMIT] = (state == S_STEP) && !value_wr && calc_limit;
    status_clr = (avs_write && (avs_address == ADDR_STATUS)) ? avs_writedata[2:0] : 3'b000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      value        <= RESET_VALUE;
      ctrl         <= '{step: DEFAULT_STEP, irq_en: 1'b0, wrap: 1'b1, enable: 1'b1};
      status       <= '0;
      events       <= '0;
      pend_dir     <= 1'b0;
      pend_step    <= 4'd0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (value_wr) state <= S_LOAD;
      else if (accepted) state <= S_STEP;
      else state <= S_IDLE;

      // A CPU load always overrides the latched event.
      if (value_wr) value <= avs_writedata[7:0];
      else if (state == S_STEP) value <= calc_next;

      if (accepted) begin
        pend_dir  <= rotary_ccw;
        pend_step <= eff_step;
      end

      status <= (status & ~status_clr) | status_set;

      if (avs_write && (avs_address == ADDR_EVENTS)) events <= '0;
      else if (accepted && rotary_cw && (events != EVENTS_MAX)) events <= events + 16'sd1;
      else if (accepted && rotary_ccw && (events != EVENTS_MIN)) events <= events - 16'sd1;

      if (avs_write && (avs_address == ADDR_CTRL)) begin
        ctrl <= '{step: avs_writedata[CTRL_STEP_LO +: 4], irq_en: avs_writedata[CTRL_IRQ_EN],
                  wrap: avs_writedata[CTRL_WRAP], enable: avs_writedata[CTRL_ENABLE]};
      end

      irq <= ctrl.irq_en && (status != 3'b000);

      if (avs_read) begin
        case (avs_address)
          ADDR_VALUE:  avs_readdata <= {24'd0, value};
          ADDR_CTRL:   avs_readdata <= ctrl_word(ctrl);
          ADDR_STATUS: avs_readdata <= {29'd0, status};
          default:     avs_readdata <= {16'd0, events};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rotary_value_reg.sv
// Bench for rotary_value_reg: directed vector table, async-reset and
// acceleration sequences (ROTARY_ACCEL_EN), then random traffic against a model.
module tb_rotary_value_reg;

  localparam logic [7:0] RST_VAL = 8'd0;
  localparam int WINDOW = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cw = 1'b0, ccw = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd = '0;
  logic [7:0]  value;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rotary_value_reg #(
    .RESET_VALUE  (RST_VAL),
    .DEFAULT_STEP (4'd1),
    .ACCEL_WINDOW (20'(WINDOW))
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rotary_cw     (cw),
    .rotary_ccw    (ccw),
    .value         (value),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wd),
    .avs_readdata  (readdata),
    .irq           (irq)
  );

  // ---------------- reference model (plain integer arithmetic) ----------------
  int   m_value, m_events, m_step, m_pstep, m_prev_cyc, cyc;
  logic m_en, m_wrap, m_irq_en, m_irq, m_pend, m_pdir, m_prev_valid, m_prev_dir;
  logic [2:0]  m_status;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_value = RST_VAL; m_events = 0; m_step = 1; m_en = 1; m_wrap = 1; m_irq_en = 0;
    m_status = 0; m_rd = 0; m_irq = 0; m_pend = 0; m_pdir = 0; m_pstep = 0;
    m_prev_valid = 0; m_prev_dir = 0; m_prev_cyc = 0; cyc = 0;
  endtask

  task automatic model_edge();
    int nv, r, base, eff;
    logic lim, vwr, acc, fast;
    logic [2:0] set, clr;
    logic [15:0] ev16;
    nv = m_value; lim = 0;
    if (m_pend) begin
      r = m_pdir ? m_value - m_pstep : m_value + m_pstep;
      if (m_wrap) r = (r + 256) % 256;
      else if (r < 0) begin r = 0; lim = 1; end
      else if (r > 255) begin r = 255; lim = 1; end
      nv = r;
    end
    vwr = wr && addr == 2'd0;
    if (vwr) begin nv = int'(wd[7:0]); lim = 0; end
    acc = m_en && (cw != ccw) && !vwr;
    base = (m_step == 0) ? 1 : m_step;
    eff = base;
    fast = m_prev_valid && (m_prev_dir == ccw) && (cyc - m_prev_cyc <= WINDOW);
`ifdef ROTARY_ACCEL_EN
    if (fast) eff = (base * 4 > 15) ? 15 : base * 4;
`endif
    ev16 = m_events[15:0];
    if (rd) begin
      case (addr)
        2'd0: m_rd = 32'(m_value);
        2'd1: m_rd = 32'(m_step * 16 + (m_irq_en ? 4 : 0) + (m_wrap ? 2 : 0) + (m_en ? 1 : 0));
        2'd2: m_rd = {29'd0, m_status};
        default: m_rd = {16'd0, ev16};
      endcase
    end
    m_irq = m_irq_en && (m_status != 0);
    set = {lim, m_en & ccw, m_en & cw};
    clr = (wr && addr == 2'd2) ? wd[2:0] : 3'b000;
    m_status = (m_status & ~clr) | set;
    if (wr && addr == 2'd3) m_events = 0;
    else if (acc && cw) m_events = (m_events == 32767) ? 32767 : m_events + 1;
    else if (acc && ccw) m_events = (m_events == -32767) ? -32767 : m_events - 1;
    if (wr && addr == 2'd1) begin
      m_step = int'(wd[7:4]); m_irq_en = wd[2]; m_wrap = wd[1]; m_en = wd[0];
    end
    m_pend = acc; m_pdir = ccw; m_pstep = eff;
    if (acc) begin m_prev_valid = 1; m_prev_dir = ccw; m_prev_cyc = cyc; end
    cyc++;
    m_value = nv;
  endtask

  // ---------------- driver / checker ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cw = 0; ccw = 0; wr = 0; rd = 0; addr = 0; wd = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          gap;
    logic        cw, ccw, wr, rd;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_value;
    logic        exp_irq;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int gap, logic c, logic cc, logic w, logic r, logic [1:0] a,
                              logic [31:0] d, logic [7:0] ev, logic ei, logic cr, logic [31:0] er);
    vec_t v;
    v.gap = gap; v.cw = c; v.ccw = cc; v.wr = w; v.rd = r; v.addr = a; v.wd = d;
    v.exp_value = ev; v.exp_irq = ei; v.chk_rd = cr; v.exp_rd = er;
    return v;
  endfunction

  initial begin
    // 3 cw pulses, step 1, wrap
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0));
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 8'h03, 0, 1, 32'h3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h03, 0, 1, 32'h1));
    // wrap from 0xFE
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'hFE, 8'hFE, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 32'h7, 8'hFE, 0, 0, 0));
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'hFE, 0, 0, 0));
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(11, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h01, 0, 1, 32'h1));
    // clamp at 0, limit flag, irq
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 32'h7, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h41, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h02, 8'h02, 0, 0, 0));
    vecs.push_back(mk(11, 0, 1, 0, 0, 0, 0, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h00, 0, 1, 32'h6));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h45, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 32'h2, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 32'h4, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h00, 0, 1, 32'h0));
    // simultaneous cw+ccw
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h13, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h10, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 32'h0, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h10, 0, 1, 32'h3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 8'h10, 0, 1, 32'h0));
    // VALUE write coincident with cw
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 32'h7, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h55, 8'h55, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h55, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 8'h55, 0, 1, 32'h1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 1, 32'h55));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'h55, 0, 1, 32'h13));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 8'h55, 0, 1, 32'h0));
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", 32'(value), 32'(RST_VAL));
    check("reset_irq", 32'(irq), 0);
    check("reset_readdata", readdata, 0);
    reset_n = 1;
    rd = 1; addr = 2'd1;
    tick();
    check("reset_ctrl", readdata, 32'h13);
    rd = 1; addr = 2'd2;
    tick();
    check("reset_status", readdata, 32'h0);
    idle();

    for (int i = 0; i < vecs.size(); i++) begin
      idle();
      repeat (vecs[i].gap) tick();
      cw = vecs[i].cw; ccw = vecs[i].ccw; wr = vecs[i].wr; rd = vecs[i].rd;
      addr = vecs[i].addr; wd = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end
    idle();

    // asynchronous reset mid-sequence, away from any clock edge
    cw = 1;
    tick();
    cw = 0;
    #2 reset_n = 0;
    #1;
    check("async_reset_value", 32'(value), 32'(RST_VAL));
    check("async_reset_irq", 32'(irq), 0);
    model_reset();
    repeat (2) tick();
    reset_n = 1;
    tick();

`ifdef ROTARY_ACCEL_EN
    // step 2: fast second pulse gets 8, slow third gets 2
    wr = 1; addr = 2'd1; wd = 32'h23;
    tick();
    idle(); cw = 1;
    tick();
    idle();
    tick();
    check("accel_first", 32'(value), 32'h02);
    repeat (3) tick();
    cw = 1;
    tick();
    idle();
    tick();
    check("accel_fast", 32'(value), 32'h0A);
    repeat (19) tick();
    cw = 1;
    tick();
    idle();
    tick();
    check("accel_timeout", 32'(value), 32'h0C);
`endif

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cw = ($urandom_range(0, 2) == 0);
      ccw = ($urandom_range(0, 2) == 0);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 11) == 0);
      addr = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (wr && addr == 2'd1 && $urandom_range(0, 7) != 0) wd[0] = 1'b1;
      if (wr && addr == 2'd3 && $urandom_range(0, 1) == 0) wr = 0;
      tick();
      check("rand_value", 32'(value), 32'(m_value));
      check("rand_irq", 32'(irq), 32'(m_irq));
      check("rand_readdata", readdata, m_rd);
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
